// File: rtl/rng_sample_unpacker.sv
// rng_sample_unpacker: slices 96-bit rng96 words into SAMPLE_W-bit samples,
// LSB slice first, with optional bound rejection and a small output FIFO.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   flush        rng96 loadseed strobe; drops word, slot state and FIFO
//   rand_in      96-bit random word
//   rand_valid   rand_in is fresh this cycle
//   bound        acceptance bound (0 = accept every slice)
//   sample_out   FIFO head (0 while empty)
//   sample_valid FIFO non-empty
//   sample_ready consumer takes sample_out this cycle
//   fifo_level   FIFO occupancy
//   reject_cnt   saturating rejected-slice count (0 without stats)
//   accept_cnt   wrapping push count (only with stats)
//
// Build option: define RNG_UNPACK_STATS_EN to enable the reject/accept
// counters. Without it reject_cnt is tied to 0 and no counter flops exist.

module rng_sample_unpacker #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [95:0]                 rand_in,
    input  logic                        rand_valid,
    input  logic [SAMPLE_W-1:0]         bound,
    output logic [SAMPLE_W-1:0]         sample_out,
    output logic                        sample_valid,
    input  logic                        sample_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 reject_cnt
`ifdef RNG_UNPACK_STATS_EN
    ,
    output logic [31:0]                 accept_cnt
`endif
);

    localparam int SLOTS = 96 / SAMPLE_W;
    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // Elaboration-time parameter sanity checks.
    if ((96 % SAMPLE_W) != 0) begin : g_bad_sample_w
        $error("SAMPLE_W must divide 96");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2, minimum 2");
    end

    typedef enum logic {
        S_EMPTY,
        S_UNPACK
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [95:0]        word_q, word_d;
    logic [IDX_W-1:0]   slot_idx_q, slot_idx_d;

    logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;

    // ------------------------------------------------------------------
    // Slice selection
    // ------------------------------------------------------------------
    logic [SAMPLE_W-1:0] slots [SLOTS];
    logic [SAMPLE_W-1:0] slice;

    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        assign slots[k] = word_q[k*SAMPLE_W +: SAMPLE_W];
    end

    assign slice = slots[slot_idx_q];

    // ------------------------------------------------------------------
    // Per-cycle decisions
    // ------------------------------------------------------------------
    logic unpacking;
    logic accept_slice;
    logic pop;
    logic space;
    logic push;
    logic reject;
    logic consumed;
    logic last_slot;
    logic do_push;
    logic do_pop;

    always_comb begin
        unpacking    = (state_q == S_UNPACK);
        accept_slice = (bound == '0) || (slice < bound);
        pop          = (level_q != '0) && sample_ready;
        // A pop in the same cycle frees a slot even when full.
        space        = (level_q < LVL_W'(FIFO_DEPTH)) || pop;
        push         = unpacking && accept_slice && space;
        // Rejections never wait on FIFO space.
        reject       = unpacking && !accept_slice;
        consumed     = push || reject;
        last_slot    = (slot_idx_q == IDX_W'(SLOTS - 1));
        // Flush drops any push or pop that coincides with it.
        do_push      = push && !flush;
        do_pop       = pop && !flush;
    end

    // ------------------------------------------------------------------
    // Unpack FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        slot_idx_d = slot_idx_q;

        case (state_q)
            S_EMPTY: begin
                if (rand_valid) begin
                    word_d     = rand_in;
                    slot_idx_d = '0;
                    state_d    = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (consumed) begin
                    if (last_slot) begin
                        slot_idx_d = '0;
                        if (rand_valid) begin
                            // Chain straight into the next word.
                            word_d = rand_in;
                        end else begin
                            state_d = S_EMPTY;
                        end
                    end else begin
                        slot_idx_d = slot_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        if (flush) begin
            state_d    = S_EMPTY;
            slot_idx_d = '0;
            word_d     = '0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO: next state
    // ------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = slice;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_EMPTY;
            word_q     <= '0;
            slot_idx_q <= '0;
            mem_q      <= '{default: '0};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            slot_idx_q <= slot_idx_d;
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sample_valid = (level_q != '0);
    // Gate the head so stale storage never shows while empty.
    assign sample_out   = sample_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level   = level_q;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef RNG_UNPACK_STATS_EN
    logic [15:0] reject_cnt_q, reject_cnt_d;
    logic [31:0] accept_cnt_q, accept_cnt_d;

    always_comb begin
        reject_cnt_d = reject_cnt_q;
        accept_cnt_d = accept_cnt_q;
        // A slice evaluated in a flush cycle is discarded, not counted.
        if (reject && !flush && (reject_cnt_q != 16'hFFFF)) begin
            reject_cnt_d = reject_cnt_q + 16'd1;
        end
        if (do_push) begin
            accept_cnt_d = accept_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            reject_cnt_q <= '0;
            accept_cnt_q <= '0;
        end else begin
            reject_cnt_q <= reject_cnt_d;
            accept_cnt_q <= accept_cnt_d;
        end
    end

    assign reject_cnt = reject_cnt_q;
    assign accept_cnt = accept_cnt_q;
`else
    assign reject_cnt = '0;
`endif

endmodule

// File: tb/tb_rng_sample_unpacker.sv
// tb_rng_sample_unpacker: directed vector bench for rng_sample_unpacker.
// Inputs driven 1 time unit after each rising edge, outputs sampled there.

module tb_rng_sample_unpacker;

    localparam logic [95:0] W1 = 96'hdeadbeef1234567890abcdef;
    localparam logic [95:0] W2 = 96'h111122223333444455556666;
    localparam logic [15:0] B8 = 16'h8000;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [95:0] rand_in;
    logic        rand_valid;
    logic [15:0] bound;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        sample_ready;
    logic [2:0]  fifo_level;
    logic [15:0] reject_cnt;
`ifdef RNG_UNPACK_STATS_EN
    logic [31:0] accept_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rng_sample_unpacker #(
        .SAMPLE_W  (16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .rand_in     (rand_in),
        .rand_valid  (rand_valid),
        .bound       (bound),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .fifo_level  (fifo_level),
        .reject_cnt  (reject_cnt)
`ifdef RNG_UNPACK_STATS_EN
        ,
        .accept_cnt  (accept_cnt)
`endif
    );

    typedef struct {
        logic        r;
        logic        f;
        logic        v;
        logic [95:0] w;
        logic [15:0] b;
        logic        rdy;
        logic        ev;
        logic [15:0] eo;
        logic [2:0]  el;
        logic [15:0] erej;
        string       nm;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [15:0] exp_rej(input logic [15:0] n);
`ifdef RNG_UNPACK_STATS_EN
        return n;
`else
        return 16'd0 & n;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic v,
                        input logic [95:0] w, input logic [15:0] b,
                        input logic rdy, input logic ev,
                        input logic [15:0] eo, input logic [2:0] el,
                        input logic [15:0] erej, input string nm);
        rst          = r;
        flush        = f;
        rand_valid   = v;
        rand_in      = w;
        bound        = b;
        sample_ready = rdy;
        @(posedge clk);
        #1;
        chk({nm, ".valid"}, 32'(sample_valid), 32'(ev));
        chk({nm, ".level"}, 32'(fifo_level), 32'(el));
        chk({nm, ".rej"}, 32'(reject_cnt), 32'(exp_rej(erej)));
        if (ev || !r) begin
            chk({nm, ".out"}, 32'(sample_out), 32'(eo));
        end
    endtask

    task automatic add(input logic r, input logic f, input logic v,
                       input logic [95:0] w, input logic [15:0] b,
                       input logic rdy, input logic ev,
                       input logic [15:0] eo, input logic [2:0] el,
                       input logic [15:0] erej, input string nm);
        vec_t t;
        t.r = r; t.f = f; t.v = v; t.w = w; t.b = b; t.rdy = rdy;
        t.ev = ev; t.eo = eo; t.el = el; t.erej = erej; t.nm = nm;
        tbl.push_back(t);
    endtask

    logic [15:0] s1 [6];
    logic [15:0] s2 [6];

    initial begin
        s1 = '{16'hcdef, 16'h90ab, 16'h5678, 16'h1234, 16'hbeef, 16'hdead};
        s2 = '{16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};

        rst = 1'b0; flush = 1'b0; rand_valid = 1'b0; rand_in = '0;
        bound = '0; sample_ready = 1'b0;

        // r f v word bound rdy | ev out lvl rej
        add(0, 0, 0, 96'h0, 0,  0, 0, 16'h0,    0, 0, "rst0");
        add(0, 1, 1, W1,    0,  1, 0, 16'h0,    0, 0, "rst_ovr");
        add(1, 0, 0, W1,    0,  1, 0, 16'h0,    0, 0, "rst_idle");
        // basic unpack
        add(1, 0, 1, W1,    0,  1, 0, 16'h0,    0, 0, "bas_cap");
        add(1, 0, 0, W1,    0,  1, 1, 16'hcdef, 1, 0, "bas0");
        add(1, 0, 0, W1,    0,  1, 1, 16'h90ab, 1, 0, "bas1");
        add(1, 0, 0, W1,    0,  1, 1, 16'h5678, 1, 0, "bas2");
        add(1, 0, 0, W1,    0,  1, 1, 16'h1234, 1, 0, "bas3");
        add(1, 0, 0, W1,    0,  1, 1, 16'hbeef, 1, 0, "bas4");
        add(1, 0, 0, W1,    0,  1, 1, 16'hdead, 1, 0, "bas5");
        add(1, 0, 0, W1,    0,  1, 0, 16'h0,    0, 0, "bas_end");
        // rejection with bound 0x8000
        add(1, 0, 1, W1,    B8, 1, 0, 16'h0,    0, 0, "rej_cap");
        add(1, 0, 0, W1,    B8, 1, 0, 16'h0,    0, 1, "rej0");
        add(1, 0, 0, W1,    B8, 1, 0, 16'h0,    0, 2, "rej1");
        add(1, 0, 0, W1,    B8, 1, 1, 16'h5678, 1, 2, "rej2");
        add(1, 0, 0, W1,    B8, 1, 1, 16'h1234, 1, 2, "rej3");
        add(1, 0, 0, W1,    B8, 1, 0, 16'h0,    0, 3, "rej4");
        add(1, 0, 0, W1,    B8, 1, 0, 16'h0,    0, 4, "rej5");
        add(1, 0, 0, W1,    B8, 1, 0, 16'h0,    0, 4, "rej_end");
        // backpressure
        add(1, 0, 1, W1,    0,  0, 0, 16'h0,    0, 4, "bp_cap");
        add(1, 0, 0, W1,    0,  0, 1, 16'hcdef, 1, 4, "bp_l1");
        add(1, 0, 0, W1,    0,  0, 1, 16'hcdef, 2, 4, "bp_l2");
        add(1, 0, 0, W1,    0,  0, 1, 16'hcdef, 3, 4, "bp_l3");
        add(1, 0, 0, W1,    0,  0, 1, 16'hcdef, 4, 4, "bp_l4");
        add(1, 0, 0, W1,    0,  0, 1, 16'hcdef, 4, 4, "bp_stall1");
        add(1, 0, 0, W1,    0,  0, 1, 16'hcdef, 4, 4, "bp_stall2");
        add(1, 0, 0, W1,    0,  1, 1, 16'h90ab, 4, 4, "bp_d1");
        add(1, 0, 0, W1,    0,  1, 1, 16'h5678, 4, 4, "bp_d2");
        add(1, 0, 0, W1,    0,  1, 1, 16'h1234, 3, 4, "bp_d3");
        add(1, 0, 0, W1,    0,  1, 1, 16'hbeef, 2, 4, "bp_d4");
        add(1, 0, 0, W1,    0,  1, 1, 16'hdead, 1, 4, "bp_d5");
        add(1, 0, 0, W1,    0,  1, 0, 16'h0,    0, 4, "bp_end");

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].w, tbl[i].b,
                 tbl[i].rdy, tbl[i].ev, tbl[i].eo, tbl[i].el,
                 tbl[i].erej, tbl[i].nm);
        end

        // Back-to-back words: 12 samples on 12 consecutive cycles.
        step(1, 0, 1, W1, 0, 1, 0, 16'h0, 0, 4, "b2b_cap");
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 1, W2, 0, 1, 1, s1[i], 1, 4, $sformatf("b2b_w1_%0d", i));
        end
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, W2, 0, 1, 1, s2[i], 1, 4, $sformatf("b2b_w2_%0d", i));
        end
        step(1, 0, 0, W2, 0, 1, 0, 16'h0, 0, 4, "b2b_end");

        // Flush with two popped and two buffered.
        step(1, 0, 1, W1, 0, 1, 0, 16'h0,    0, 4, "fl_cap");
        step(1, 0, 0, W1, 0, 1, 1, 16'hcdef, 1, 4, "fl_s0");
        step(1, 0, 0, W1, 0, 1, 1, 16'h90ab, 1, 4, "fl_s1");
        step(1, 0, 0, W1, 0, 1, 1, 16'h5678, 1, 4, "fl_s2");
        step(1, 0, 0, W1, 0, 0, 1, 16'h5678, 2, 4, "fl_buf2");
        step(1, 1, 1, W1, 0, 1, 0, 16'h0,    0, 4, "fl_flush");
        step(1, 0, 0, W1, 0, 1, 0, 16'h0,    0, 4, "fl_idle");
        step(1, 0, 1, W2, 0, 1, 0, 16'h0,    0, 4, "fl_recap");
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, W2, 0, 1, 1, s2[i], 1, 4, $sformatf("fl_w2_%0d", i));
        end
        step(1, 0, 0, W2, 0, 1, 0, 16'h0, 0, 4, "fl_end");

        // Reset while full with bound 0x8000.
        step(1, 0, 1, W2, B8, 0, 0, 16'h0,    0, 4, "rm_cap");
        step(1, 0, 0, W2, B8, 0, 1, 16'h6666, 1, 4, "rm_l1");
        step(1, 0, 0, W2, B8, 0, 1, 16'h6666, 2, 4, "rm_l2");
        step(1, 0, 0, W2, B8, 0, 1, 16'h6666, 3, 4, "rm_l3");
        step(1, 0, 0, W2, B8, 0, 1, 16'h6666, 4, 4, "rm_l4");
        step(0, 0, 0, W2, B8, 0, 0, 16'h0,    0, 0, "rm_rst");
        step(1, 0, 0, W2, 0,  1, 0, 16'h0,    0, 0, "rm_idle");
        step(1, 0, 1, W1, 0,  1, 0, 16'h0,    0, 0, "rm_cap2");
        step(1, 0, 0, W1, 0,  1, 1, 16'hcdef, 1, 0, "rm_s0");
        step(1, 0, 0, W1, 0,  1, 1, 16'h90ab, 1, 0, "rm_s1");
`ifdef RNG_UNPACK_STATS_EN
        chk("accept_cnt", accept_cnt, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rng_sample_unpacker.md
Name: rng_sample_unpacker

Overview:
- Sits directly downstream of rng96. Captures its 96-bit random_out words and slices each into SAMPLE_W-bit samples, LSB slice first.
- Optionally rejects samples at or above a programmable bound, giving unbiased draws in [0, bound).
- Buffers accepted samples in a small FIFO and hands them to consumers over a valid/ready handshake.
- Flushes all state when the RNG is reseeded.

Parameters:
- SAMPLE_W, 16, sample width in bits; legal values 8, 12, 16, 24, 32, 48 (must divide 96).
- FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-low reset; rst=0 at a rising edge resets the block.
- flush  input  1  driven by the rng96 loadseed strobe; discards all buffered data.
- rand_in  input  96  random word from rng96 random_out.
- rand_valid  input  1  rand_in is a fresh word this cycle; tie to 1 for a free-running rng96.
- bound  input  SAMPLE_W  acceptance bound; 0 disables rejection.
- sample_out  output  SAMPLE_W  FIFO head sample.
- sample_valid  output  1  FIFO non-empty.
- sample_ready  input  1  consumer accepts sample_out this cycle.
- fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- reject_cnt  output  16  rejected-sample counter (see Optional Feature).

Behaviour:
- SLOTS = 96/SAMPLE_W. Slot k = rand word bits [k*SAMPLE_W +: SAMPLE_W]. Slot 0 is handled first.
- Reset (rst=0):
  - word register cleared; slot_idx=0; state=EMPTY.
  - FIFO emptied; sample_valid=0, sample_out=0, fifo_level=0, reject_cnt=0.
  - Reset overrides flush and every other input.
- FSM states: EMPTY, UNPACK.
  - EMPTY: if rand_valid, capture rand_in, slot_idx=0, go to UNPACK. Otherwise stay.
  - UNPACK, each cycle: evaluate slice s = slot[slot_idx].
    - Accept when bound==0 or s < bound (unsigned compare).
    - Accepted: push s into the FIFO if space exists; space = level<FIFO_DEPTH, or a pop occurs the same cycle. Otherwise stall: slot_idx and word hold, nothing is lost.
    - Rejected: no push; reject_cnt increments; slot_idx advances regardless of FIFO state.
    - When slot_idx==SLOTS-1 and the slot is consumed (pushed or rejected):
      - rand_valid=1: capture the new word the same cycle, slot_idx=0, stay in UNPACK. Back-to-back words give no bubble.
      - rand_valid=0: go to EMPTY.
- Latency: word sampled at edge N -> slot 0 pushed at edge N+1 -> sample_valid=1 after edge N+1 (empty FIFO, accepted slice).
- Throughput: at most one push per cycle.
- FIFO:
  - Pop when sample_valid & sample_ready.
  - Simultaneous push and pop leaves level unchanged, including when full.
  - Pop on empty is ignored.
  - sample_out shows the head entry combinationally from FIFO storage; it holds stable while valid & !ready.
- flush=1 at an edge (rst=1):
  - FIFO emptied, slot_idx=0, state=EMPTY, word discarded; reject_cnt unchanged.
  - A simultaneous pop or push is dropped.
  - rand_in is not captured that cycle, so the first post-flush word comes from the cycle after flush.
- bound is sampled combinationally at each slice evaluation. A change affects the next evaluated slice only; already-buffered samples are kept.
- reject_cnt saturates at 16'hFFFF.

Optional Feature:
- Macro RNG_UNPACK_STATS_EN.
- Defined:
  - reject_cnt is live as described above.
  - An extra output accept_cnt[31:0] counts FIFO pushes, wrapping at 2^32.
  - Both counters clear on reset only.
- Undefined:
  - reject_cnt is tied to 0 and accept_cnt does not exist.
  - No counter flops are synthesized.
  - Rejection logic is unaffected.

Test Plan:
- Basic unpack: reset, then rand_valid pulse with 96'hdeadbeef1234567890abcdef, bound=0, sample_ready=1 -> samples 16'hcdef, 90ab, 5678, 1234, beef, dead on consecutive cycles; first valid one edge after capture; then sample_valid=0.
- Rejection: same word, bound=16'h8000 -> only 5678 and 1234 emitted; reject_cnt=4 (macro on), 0 (macro off).
- Backpressure: same word, bound=0, sample_ready=0 -> fifo_level reaches 4, sample_out holds cdef, slot_idx stalls at 4. Raise ready -> cdef, 90ab, 5678, 1234, beef, dead in order, with no loss or duplication.
- Back-to-back words: rand_valid=1 continuously, two distinct words, ready=1 -> 12 samples with no idle cycle between word 1's dead slice and word 2's slot 0.
- Flush mid-word: assert flush after 2 samples popped, with 2 buffered -> next cycle sample_valid=0, fifo_level=0. The next rand_valid word restarts at its slot 0.
- Reset mid-operation: rst=0 for one edge while FIFO full and bound=16'h8000 -> all outputs 0, state EMPTY. Normal unpack resumes on the next word.
